// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack memory port
// and hands them to decode over valid/ready, with redirect, kill and timeout handling.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  Opcode,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

    localparam logic [15:0] TLIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [31:0] pc;
    logic        kill;
    logic [15:0] tcnt;

    logic        redir_ok;
    logic        redir_bad;
    logic        handshake;
    logic [31:0] next_pc;

    assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign handshake = inst_valid && inst_ready;
    assign next_pc   = redir_ok ? redirect_pc : pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            tcnt       <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            Opcode     <= '0;
            fetch_err  <= 1'b0;
        end else if (state != ERR && redir_bad) begin
            // A misaligned target is fatal; any outstanding ack is dropped in ERR.
            state      <= ERR;
            fetch_err  <= 1'b1;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            kill       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pc <= next_pc;
                    if (en) begin
                        state     <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= next_pc;
                        tcnt      <= '0;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (kill || redir_ok) begin
                            // Stale data: reissue at the redirected PC.
                            kill      <= 1'b0;
                            pc        <= next_pc;
                            imem_addr <= next_pc;
                            tcnt      <= '0;
                        end else begin
                            inst       <= imem_rdata;
                            Opcode     <= imem_rdata[6:0];
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            pc         <= pc + 32'd4;
                            imem_req   <= 1'b0;
                            state      <= HOLD;
                        end
                    end else begin
                        if (redir_ok) begin
                            kill <= 1'b1;
                            pc   <= redirect_pc;
                        end
                        if (tcnt == TLIMIT) begin
                            state     <= ERR;
                            fetch_err <= 1'b1;
                            imem_req  <= 1'b0;
                            kill      <= 1'b0;
                        end else begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end
                end
                HOLD: begin
                    pc <= next_pc;
                    if (handshake || redir_ok) begin
                        inst_valid <= 1'b0;
                        if (en) begin
                            state     <= FETCH;
                            imem_req  <= 1'b1;
                            imem_addr <= next_pc;
                            tcnt      <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory responder, a decode-side monitor
// popping expected {inst, pc} pairs, and directed stimulus with hand-computed values.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  Opcode;
    logic        fetch_err;

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_q[$];
    int          lat;
    bit          mem_on;

    instr_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset), .en(en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .Opcode(Opcode), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // Word at address A is {A[24:0], 7'h33}; address 0 therefore returns 32'h0000_0033.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[24:0], 7'h33};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory responder: acks after lat idle request cycles, one-cycle strobe.
    initial begin
        int wcnt;
        wcnt = 0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_ack) begin
                imem_ack = 1'b0;
                wcnt = 0;
            end else if (imem_req && mem_on && !reset) begin
                if (wcnt >= lat) begin
                    imem_ack = 1'b1;
                    imem_rdata = memword(imem_addr);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Decode-side monitor and request-address stability watch.
    initial begin
        logic [63:0] e;
        logic        prev_req;
        logic        prev_ack;
        logic [31:0] prev_addr;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!reset && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_inst", inst, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("inst", inst, e[63:32]);
                    check("inst_pc", inst_pc, e[31:0]);
                    check("opcode", {25'd0, Opcode}, {25'd0, e[38:32]});
                end
            end
            if (!reset && prev_req && imem_req && !prev_ack)
                check("addr_stable", imem_addr, prev_addr);
            prev_req = imem_req && !reset;
            prev_ack = imem_ack;
            prev_addr = imem_addr;
        end
    end

    task automatic wait_valid();
        int w;
        w = 0;
        while (!inst_valid && w < 50) begin
            cyc(1);
            w++;
        end
        if (!inst_valid) check("wait_valid_timeout", {31'd0, inst_valid}, 32'd1);
    endtask

    // Expect one instruction, accept it (optionally with a redirect), check the next request.
    task automatic take(input logic [31:0] ei, input logic [31:0] ep,
                        input bit redir, input logic [31:0] rpc);
        exp_q.push_back({ei, ep});
        wait_valid();
        inst_ready = 1'b1;
        if (redir) begin
            redirect_valid = 1'b1;
            redirect_pc = rpc;
        end
        cyc(1);
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        check("next_req", {31'd0, imem_req}, 32'd1);
        check("next_addr", imem_addr, redir ? rpc : ep + 32'd4);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        check({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
        check({tag, "_inst"}, inst, 32'h0);
        check({tag, "_inst_pc"}, inst_pc, 32'h0);
        check({tag, "_opcode"}, {25'd0, Opcode}, 32'h0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        en = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        lat = 0;
        mem_on = 1'b1;
        cyc(2);
        check_reset_outputs("rst");

        // Zero-wait fetch of an R-type word at 0x0, next request at 0x4.
        reset = 1'b0;
        en = 1'b1;
        cyc(1);
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        take(32'h0000_0033, 32'h0, 1'b0, 32'h0);

        // Backpressure: payload stable, no new request.
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("hold_inst", inst, 32'h0000_0233);
            check("hold_pc", inst_pc, 32'h4);
            check("hold_opcode", {25'd0, Opcode}, 32'h33);
            check("hold_noreq", {31'd0, imem_req}, 32'd0);
            cyc(1);
        end
        lat = 3;
        take(32'h0000_0233, 32'h4, 1'b0, 32'h0);

        // Redirect to 0x100 while the slow fetch of 0x8 is outstanding.
        cyc(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        cyc(1);
        redirect_valid = 1'b0;
        check("kill_req", {31'd0, imem_req}, 32'd1);
        check("kill_old_addr", imem_addr, 32'h8);
        take(32'h0000_8033, 32'h100, 1'b0, 32'h0);
        lat = 0;

        // Redirect together with a handshake: accepted once, refetch at target.
        take(32'h0000_8233, 32'h104, 1'b1, 32'h200);
        take(32'h0001_0033, 32'h200, 1'b0, 32'h0);

        // Redirect in HOLD without handshake squashes 0x204.
        wait_valid();
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        cyc(1);
        redirect_valid = 1'b0;
        check("squash_valid", {31'd0, inst_valid}, 32'd0);
        check("squash_req", {31'd0, imem_req}, 32'd1);
        check("squash_addr", imem_addr, 32'h300);
        take(32'h0001_8033, 32'h300, 1'b0, 32'h0);

        // Misaligned redirect: sticky error, quiescent outputs.
        wait_valid();
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        cyc(1);
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("mis_err", {31'd0, fetch_err}, 32'd1);
            check("mis_req", {31'd0, imem_req}, 32'd0);
            check("mis_valid", {31'd0, inst_valid}, 32'd0);
            cyc(1);
        end
        inst_ready = 1'b0;
        reset = 1'b1;
        #2;
        check_reset_outputs("rst_err");
        cyc(1);

        // Memory never answers: error after 255 request cycles.
        mem_on = 1'b0;
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            cyc(1);
            if (fetch_err) break;
            if (imem_req) n++;
        end
        check("timeout_cycles", n, 32'd255);
        check("timeout_err", {31'd0, fetch_err}, 32'd1);
        check("timeout_req", {31'd0, imem_req}, 32'd0);

        // Reset in ERR, then fetching resumes at RESET_PC.
        reset = 1'b1;
        #2;
        check_reset_outputs("rst_to");
        cyc(1);
        mem_on = 1'b1;
        reset = 1'b0;
        cyc(1);
        check("resume_req", {31'd0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, 32'h0);
        take(32'h0000_0033, 32'h0, 1'b0, 32'h0);
        en = 1'b0;
        cyc(3);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
